mem_stage_wb: RTL and testbench

- Memory stage of the 5-stage RISC-V pipeline: consumes the EX/MEM register outputs (the M-stage signals) and performs load/store accesses over a req/ack data-memory handshake.
- Handles byte/halfword/word alignment, byte enables and load sign/zero extension.
- Stalls the front of the pipeline while memory is busy.
- Registers the results into the MEM/WB boundary that feeds writeback.

---
 rtl/mem_stage_wb_pkg.sv | 20 ++
 rtl/mem_stage_wb_align.sv | 72 +++++++
 rtl/mem_stage_wb.sv | 143 ++++++++++++++
 tb/tb_mem_stage_wb.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_wb_pkg.sv
// Shared encodings for the memory stage: writeback source select, access-size
// funct3 values and the handshake FSM states.
package mem_stage_wb_pkg;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

endpackage

// File: rtl/mem_stage_wb_align.sv
// Combinational lane logic: byte enables, replicated store data, the
// misaligned/illegal fault flag and the sign/zero-extended load value.
module load_store_align
  import mem_stage_wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            is_load,
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] load_word,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic            fault,
  output logic [XLEN-1:0] load_value
);

  logic        legal;
  logic        aligned;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    legal      = 1'b0;
    aligned    = 1'b0;
    be         = 4'b1111;
    wdata      = store_data;
    byte_sel   = load_word[{offset, 3'b000} +: 8];
    half_sel   = load_word[{offset[1], 4'b0000} +: 16];
    load_value = load_word;

    case (funct3)
      F3_B, F3_BU: aligned = 1'b1;
      F3_H, F3_HU: aligned = ~offset[0];
      F3_W:        aligned = (offset == 2'b00);
      default:     aligned = 1'b0;
    endcase

    if (is_store)
      legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    else
      legal = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};

    fault = (is_load | is_store) & ~(legal & aligned);

    // Loads always fetch the whole word; only stores narrow the enables
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          be    = 4'b0001 << offset;
          wdata = {4{store_data[7:0]}};
        end
        2'b01: begin
          be    = 4'b0011 << offset;
          wdata = {2{store_data[15:0]}};
        end
        default: be = 4'b1111;
      endcase
    end

    case (funct3)
      F3_B:    load_value = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_value = {24'd0, byte_sel};
      F3_H:    load_value = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_value = {16'd0, half_sel};
      default: load_value = load_word;
    endcase
  end

endmodule

// File: rtl/mem_stage_wb.sv
// RISC-V memory stage: req/ack data-memory handshake with timeout, front-end
// stall generation and the MEM/WB pipeline register.
module mem_stage_wb
  import mem_stage_wb_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteM,
  input  logic [1:0]      ResultSrcM,
  input  logic            MemWriteM,
  input  logic            lui_selM,
  input  logic [2:0]      funct3M,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic [4:0]      RdM,
  input  logic [XLEN-1:0] ExtImmM,
  input  logic [XLEN-1:0] PCPlus4M,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack,
  output logic            StallM,
  output logic            misalign,
  output logic            bus_err,
  output logic            RegWriteW,
  output logic [1:0]      ResultSrcW,
  output logic            lui_selW,
  output logic [4:0]      RdW,
  output logic [XLEN-1:0] ALUResultW,
  output logic [XLEN-1:0] ReadDataW,
  output logic [XLEN-1:0] ExtImmW,
  output logic [XLEN-1:0] PCPlus4W
);

  localparam int CW = $clog2(TIMEOUT);

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic            is_store, is_load, mem_op;
  logic            fault, timeout, capture;
  logic [XLEN-1:0] load_value;

  assign is_store = MemWriteM;
  assign is_load  = ~MemWriteM & (ResultSrcM == RES_MEM);
  assign mem_op   = is_store | is_load;

  load_store_align #(.XLEN(XLEN)) u_align (
    .is_load    (is_load),
    .is_store   (is_store),
    .funct3     (funct3M),
    .offset     (ALUResultM[1:0]),
    .store_data (WriteDataM),
    .load_word  (dmem_rdata),
    .be         (dmem_be),
    .wdata      (dmem_wdata),
    .fault      (fault),
    .load_value (load_value)
  );

  // A late ack in the final wait cycle still completes the access
  assign timeout    = (state == WAIT) && (cnt == CW'(TIMEOUT - 1));
  assign dmem_req   = ~rst & mem_op & ~fault & (~timeout | dmem_ack);
  assign dmem_we    = dmem_req & is_store;
  assign dmem_addr  = {ALUResultM[XLEN-1:2], 2'b00};
  assign StallM     = dmem_req & ~dmem_ack;
  assign misalign   = ~rst & fault;
  assign bus_err    = ~rst & mem_op & ~fault & timeout & ~dmem_ack;
  assign capture    = ~StallM & ~fault & ~bus_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Leaving WAIT happens on ack or on timeout, both of which drop StallM
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (StallM) begin
          state_next = WAIT;
          cnt_next   = CW'(1);
        end
      end
      WAIT: begin
        if (StallM) begin
          cnt_next = cnt + CW'(1);
        end else begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= '0;
      lui_selW   <= 1'b0;
      RdW        <= '0;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      ExtImmW    <= '0;
      PCPlus4W   <= '0;
    end else if (capture) begin
      RegWriteW  <= RegWriteM;
      ResultSrcW <= ResultSrcM;
      lui_selW   <= lui_selM;
      RdW        <= RdM;
      ALUResultW <= ALUResultM;
      ReadDataW  <= is_load ? load_value : '0;
      ExtImmW    <= ExtImmM;
      PCPlus4W   <= PCPlus4M;
    end else begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= '0;
      lui_selW   <= 1'b0;
      RdW        <= '0;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      ExtImmW    <= '0;
      PCPlus4W   <= '0;
    end
  end

endmodule

// File: tb/tb_mem_stage_wb.sv
// Self-checking bench for mem_stage_wb: directed scenarios plus randomized
// accesses checked against a behavioural model of the memory stage.
`timescale 1ns/1ps
module tb_mem_stage_wb;

  localparam int TIMEOUT = 16;
  localparam int NEVER   = 1000;

  typedef struct packed {
    logic        rw;
    logic [1:0]  rs;
    logic        mw;
    logic        lui;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] pc4;
  } op_t;

  typedef struct {
    int          stall_n;
    int          berr_n;
    int          mis_n;
    int          req_n;
    int          bad_bubble;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] addr;
    logic        we;
    logic        hung;
  } obs_t;

  logic        clk, rst;
  logic        RegWriteM, MemWriteM, lui_selM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, WriteDataM, ExtImmM, PCPlus4M;
  logic [4:0]  RdM;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        StallM, misalign, bus_err;
  logic        RegWriteW, lui_selW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RdW;
  logic [31:0] ALUResultW, ReadDataW, ExtImmW, PCPlus4W;
  logic [136:0] wbus;

  int tests = 0;
  int fails = 0;

  assign wbus = {RegWriteW, ResultSrcW, lui_selW, RdW, ALUResultW, ReadDataW, ExtImmW, PCPlus4W};

  mem_stage_wb #(.TIMEOUT(TIMEOUT), .XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .RegWriteM  (RegWriteM),
    .ResultSrcM (ResultSrcM),
    .MemWriteM  (MemWriteM),
    .lui_selM   (lui_selM),
    .funct3M    (funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .RdM        (RdM),
    .ExtImmM    (ExtImmM),
    .PCPlus4M   (PCPlus4M),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .StallM     (StallM),
    .misalign   (misalign),
    .bus_err    (bus_err),
    .RegWriteW  (RegWriteW),
    .ResultSrcW (ResultSrcW),
    .lui_selW   (lui_selW),
    .RdW        (RdW),
    .ALUResultW (ALUResultW),
    .ReadDataW  (ReadDataW),
    .ExtImmW    (ExtImmW),
    .PCPlus4W   (PCPlus4W)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Behavioural model: access size in bytes, legality and load extension
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 1;
    endcase
  endfunction

  function automatic bit is_legal(input bit store, input logic [2:0] f3, input logic [1:0] off);
    bit ok;
    if (store) ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else       ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    return ok && ((int'(off) % size_of(f3)) == 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] word);
    longint sz, span, v;
    sz   = size_of(f3);
    span = longint'(1) << (8 * sz);
    v    = (longint'({32'd0, word}) >> (8 * int'(off))) % span;
    if ((f3 == 3'd0 || f3 == 3'd1) && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  task automatic set_nop();
    RegWriteM = 0; ResultSrcM = 0; MemWriteM = 0; lui_selM = 0; funct3M = 0;
    ALUResultM = 0; WriteDataM = 0; RdM = 0; ExtImmM = 0; PCPlus4M = 0;
    dmem_ack = 0; dmem_rdata = 0;
  endtask

  // Presents one EX/MEM entry and plays memory, acking at cycle index ack_at;
  // entered and left one time unit after a rising edge
  task automatic drive_access(input op_t op, input int ack_at, input logic [31:0] rdata,
                              output obs_t o);
    int  idx;
    bit  done, stalled;
    o = '{default: 0};
    {RegWriteM, ResultSrcM, MemWriteM, lui_selM, funct3M, ALUResultM, WriteDataM, RdM, ExtImmM, PCPlus4M} = op;
    idx  = 0;
    done = 0;
    while (!done && idx < TIMEOUT + 4) begin
      dmem_ack   = (idx == ack_at);
      dmem_rdata = (idx == ack_at) ? rdata : $urandom;
      #4;
      if (dmem_req) begin
        o.req_n++;
        o.be = dmem_be; o.wdata = dmem_wdata; o.addr = dmem_addr; o.we = dmem_we;
      end
      if (misalign) o.mis_n++;
      if (bus_err)  o.berr_n++;
      stalled = StallM;
      if (stalled) o.stall_n++;
      @(posedge clk); #1;
      if (stalled && wbus !== '0) o.bad_bubble++;
      if (!stalled) done = 1;
      idx++;
    end
    o.hung = !done;
    set_nop();
  endtask

  task automatic test_reset();
    rst = 1;
    set_nop();
    ResultSrcM = 2'b01; funct3M = 3'b010; ALUResultM = 32'h1;
    @(posedge clk); #1;
    tests++; if (misalign !== 1'b0) begin fails++; $display("[TB] FAIL reset_misalign: got %b expected 0", misalign); end
    tests++; if (dmem_req !== 1'b0) begin fails++; $display("[TB] FAIL reset_req: got %b expected 0", dmem_req); end
    tests++; if (wbus !== '0) begin fails++; $display("[TB] FAIL reset_wregs: got %h expected 0", wbus); end
    set_nop();
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_nonmem();
    obs_t o;
    op_t  op = '{rw: 1, rs: 2'b00, mw: 0, lui: 0, f3: 0, alu: 32'h1234, wd: 0, rd: 5,
                 imm: 32'h55, pc4: 32'h104};
    drive_access(op, NEVER, 0, o);
    tests++; if (o.req_n !== 0) begin fails++; $display("[TB] FAIL nonmem_req: got %0d cycles expected 0", o.req_n); end
    tests++; if (ALUResultW !== 32'h1234) begin fails++; $display("[TB] FAIL nonmem_alu: got %h expected 00001234", ALUResultW); end
    tests++; if ({RegWriteW, RdW} !== {1'b1, 5'd5}) begin fails++; $display("[TB] FAIL nonmem_rd: got %b/%0d expected 1/5", RegWriteW, RdW); end
  endtask

  task automatic test_load_ext();
    obs_t o;
    op_t  op = '{rw: 1, rs: 2'b01, mw: 0, lui: 0, f3: 3'b000, alu: 32'h103, wd: 0, rd: 7,
                 imm: 0, pc4: 32'h20};
    drive_access(op, 0, 32'h80FF_0000, o);
    tests++; if (o.stall_n !== 0) begin fails++; $display("[TB] FAIL lb_stall: got %0d expected 0", o.stall_n); end
    tests++; if (ReadDataW !== 32'hFFFF_FF80) begin fails++; $display("[TB] FAIL lb_data: got %h expected ffffff80", ReadDataW); end
    op.f3 = 3'b100;
    drive_access(op, 0, 32'h80FF_0000, o);
    tests++; if (ReadDataW !== 32'h0000_0080) begin fails++; $display("[TB] FAIL lbu_data: got %h expected 00000080", ReadDataW); end
  endtask

  task automatic test_store_wait();
    obs_t o;
    op_t  op = '{rw: 0, rs: 2'b00, mw: 1, lui: 0, f3: 3'b001, alu: 32'h102, wd: 32'hABCD_1234,
                 rd: 0, imm: 0, pc4: 32'h44};
    drive_access(op, 3, 0, o);
    tests++; if ({o.be, o.we} !== {4'b1100, 1'b1}) begin fails++; $display("[TB] FAIL sh_be: got %b/%b expected 1100/1", o.be, o.we); end
    tests++; if (o.wdata !== 32'h1234_1234) begin fails++; $display("[TB] FAIL sh_wdata: got %h expected 12341234", o.wdata); end
    tests++; if (o.addr !== 32'h100) begin fails++; $display("[TB] FAIL sh_addr: got %h expected 00000100", o.addr); end
    tests++; if (o.stall_n !== 3) begin fails++; $display("[TB] FAIL sh_stall: got %0d expected 3", o.stall_n); end
    tests++; if (o.bad_bubble !== 0) begin fails++; $display("[TB] FAIL sh_bubble: got %0d non-bubble cycles expected 0", o.bad_bubble); end
    tests++; if ({ALUResultW, PCPlus4W} !== {32'h102, 32'h44}) begin fails++; $display("[TB] FAIL sh_wentry: got %h/%h expected 102/44", ALUResultW, PCPlus4W); end
  endtask

  task automatic test_misalign();
    obs_t o;
    op_t  op = '{rw: 1, rs: 2'b01, mw: 0, lui: 0, f3: 3'b010, alu: 32'h101, wd: 0, rd: 9,
                 imm: 0, pc4: 32'h8};
    drive_access(op, 0, 32'h1111_2222, o);
    tests++; if (o.mis_n !== 1) begin fails++; $display("[TB] FAIL lw_mis_pulse: got %0d expected 1", o.mis_n); end
    tests++; if ({o.req_n, o.stall_n} !== {32'd0, 32'd0}) begin fails++; $display("[TB] FAIL lw_mis_req: got %0d/%0d expected 0/0", o.req_n, o.stall_n); end
    tests++; if (wbus !== '0) begin fails++; $display("[TB] FAIL lw_mis_bubble: got %h expected 0", wbus); end
    op.f3 = 3'b011; op.alu = 32'h100;
    drive_access(op, 0, 32'h1111_2222, o);
    tests++; if (o.mis_n !== 1) begin fails++; $display("[TB] FAIL illegal_f3: got %0d expected 1", o.mis_n); end
  endtask

  task automatic test_timeout();
    obs_t o;
    op_t  op = '{rw: 1, rs: 2'b01, mw: 0, lui: 0, f3: 3'b010, alu: 32'h200, wd: 0, rd: 3,
                 imm: 0, pc4: 32'hC};
    drive_access(op, NEVER, 0, o);
    tests++; if (o.stall_n !== TIMEOUT - 1) begin fails++; $display("[TB] FAIL to_stall: got %0d expected %0d", o.stall_n, TIMEOUT - 1); end
    tests++; if (o.berr_n !== 1) begin fails++; $display("[TB] FAIL to_buserr: got %0d expected 1", o.berr_n); end
    tests++; if (o.req_n !== TIMEOUT - 1) begin fails++; $display("[TB] FAIL to_req: got %0d expected %0d", o.req_n, TIMEOUT - 1); end
    tests++; if (RegWriteW !== 1'b0) begin fails++; $display("[TB] FAIL to_bubble: got %b expected 0", RegWriteW); end
    drive_access(op, TIMEOUT - 1, 32'hCAFE_F00D, o);
    tests++; if ({o.stall_n, o.berr_n} !== {TIMEOUT - 1, 32'd0}) begin fails++; $display("[TB] FAIL ack_wins: got %0d/%0d expected %0d/0", o.stall_n, o.berr_n, TIMEOUT - 1); end
    tests++; if (ReadDataW !== 32'hCAFE_F00D) begin fails++; $display("[TB] FAIL ack_wins_data: got %h expected cafef00d", ReadDataW); end
  endtask

  task automatic test_reset_mid_wait();
    obs_t o;
    op_t  op = '{rw: 1, rs: 2'b01, mw: 0, lui: 0, f3: 3'b010, alu: 32'h40, wd: 0, rd: 12,
                 imm: 0, pc4: 32'h18};
    logic [31:0] word;
    {RegWriteM, ResultSrcM, MemWriteM, lui_selM, funct3M, ALUResultM, WriteDataM, RdM, ExtImmM, PCPlus4M} = op;
    dmem_ack = 0;
    #4;
    tests++; if (StallM !== 1'b1) begin fails++; $display("[TB] FAIL rw_stall: got %b expected 1", StallM); end
    @(posedge clk); #1; @(posedge clk); #3;
    rst = 1;
    #1;
    tests++; if ({dmem_req, StallM, bus_err} !== 3'b000) begin fails++; $display("[TB] FAIL rw_req: got %b expected 000", {dmem_req, StallM, bus_err}); end
    tests++; if (wbus !== '0) begin fails++; $display("[TB] FAIL rw_wregs: got %h expected 0", wbus); end
    set_nop();
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    word = $urandom;
    drive_access(op, 2, word, o);
    tests++; if (o.stall_n !== 2) begin fails++; $display("[TB] FAIL rw_fresh_stall: got %0d expected 2", o.stall_n); end
    tests++; if ({RegWriteW, ReadDataW} !== {1'b1, word}) begin fails++; $display("[TB] FAIL rw_fresh_data: got %b/%h expected 1/%h", RegWriteW, ReadDataW, word); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      obs_t o;
      op_t op;
      int kind, ack_at, sz, e_stall, e_berr, e_req, e_mis;
      bit ld, st, mop, flt;
      logic [31:0] word, e_rd;
      logic [136:0] e_w;
      kind = $urandom_range(0, 2);
      ld = (kind == 1); st = (kind == 2); mop = ld | st;
      op.rw = 1'($urandom); op.lui = 1'($urandom); op.f3 = 3'($urandom_range(0, 7));
      op.alu = $urandom; op.wd = $urandom; op.rd = 5'($urandom);
      op.imm = $urandom; op.pc4 = $urandom;
      if ($urandom_range(0, 1) == 1) op.alu[1:0] = 2'b00;
      op.mw = st;
      op.rs = ld ? 2'b01 : (st ? 2'b00 : ($urandom_range(0, 1) == 1 ? 2'b10 : 2'b00));
      ack_at = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 4) : $urandom_range(13, 18);
      word = $urandom;
      sz  = size_of(op.f3);
      flt = mop && !is_legal(st, op.f3, op.alu[1:0]);
      e_mis = flt ? 1 : 0;
      if (!mop || flt) begin
        e_stall = 0; e_berr = 0; e_req = 0;
      end else begin
        e_stall = (ack_at < TIMEOUT - 1) ? ack_at : TIMEOUT - 1;
        e_berr  = (ack_at > TIMEOUT - 1) ? 1 : 0;
        e_req   = (ack_at <= TIMEOUT - 1) ? ack_at + 1 : TIMEOUT - 1;
      end
      e_rd = ld ? model_load(op.f3, op.alu[1:0], word) : 32'd0;
      e_w  = (flt || e_berr == 1) ? '0 : {op.rw, op.rs, op.lui, op.rd, op.alu, e_rd, op.imm, op.pc4};
      drive_access(op, ack_at, word, o);
      tests++; if (o.hung !== 1'b0) begin fails++; $display("[TB] FAIL rand%0d hung: stall never released", n); end
      tests++; if ({o.stall_n, o.berr_n, o.mis_n, o.req_n} !== {e_stall, e_berr, e_mis, e_req}) begin
        fails++; $display("[TB] FAIL rand%0d handshake: got stall %0d berr %0d mis %0d req %0d expected %0d %0d %0d %0d",
                          n, o.stall_n, o.berr_n, o.mis_n, o.req_n, e_stall, e_berr, e_mis, e_req); end
      tests++; if (o.bad_bubble !== 0) begin fails++; $display("[TB] FAIL rand%0d bubble: got %0d non-bubble cycles expected 0", n, o.bad_bubble); end
      tests++; if (wbus !== e_w) begin fails++; $display("[TB] FAIL rand%0d wregs: got %h expected %h", n, wbus, e_w); end
      if (e_req > 0) begin
        tests++; if ({o.addr, o.we} !== {op.alu & 32'hFFFF_FFFC, st}) begin
          fails++; $display("[TB] FAIL rand%0d addr: got %h/%b expected %h/%b", n, o.addr, o.we, op.alu & 32'hFFFF_FFFC, st); end
        tests++; if (o.be !== (st ? 4'(((1 << sz) - 1) << op.alu[1:0]) : 4'hF)) begin
          fails++; $display("[TB] FAIL rand%0d be: got %b for f3 %0d off %0d", n, o.be, op.f3, op.alu[1:0]); end
        if (st) begin
          tests++; if (o.wdata !== (sz == 1 ? (op.wd & 32'hFF) * 32'h0101_0101 :
                                   sz == 2 ? (op.wd & 32'hFFFF) * 32'h0001_0001 : op.wd)) begin
            fails++; $display("[TB] FAIL rand%0d wdata: got %h for data %h size %0d", n, o.wdata, op.wd, sz); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_load_ext();
    test_store_wait();
    test_misalign();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
